fetch_queue: RTL

Parametrised, decoupled instruction-fetch stage for the RISC-V pipeline: it owns the fetch PC, issues pipelined requests to a latency-tolerant instruction memory, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to the IF/ID register with a valid/ready handshake. On a redirect from EX (branch taken, JAL, JALR) it flushes the queue and discards in-flight responses. It is the successor of the single-cycle combinational fetch path.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fq_ring_buffer.sv | 54 +++++
 rtl/fetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and the default queue-entry type for the decoupled fetch stage.
package fetch_queue_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned PC_STEP      = 4;
  localparam int unsigned DEFAULT_XLEN = 32;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_ring_buffer.sv
// Generic DEPTH-entry FIFO ring buffer with synchronous clear; knows nothing of the memory protocol.
module fq_ring_buffer
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fq_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates visibility, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= push_data;
  end

  assign head_data = mem[head];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop && !clear) |-> (count != CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (pop && !clear) |-> (count != '0));

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, issues credit-limited imem requests,
// queues returned instructions with their PCs and flushes on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_pcplus4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_base;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop;
  logic [CW-1:0]   occupancy;
  logic            can_issue;
  logic            fire;
  logic            push;
  logic            pop;
  logic            head_valid;
  entry_t          head;

  assign redirect_base = redirect_pc & ~XLEN'(3);

  // Credit counts queued entries plus live in-flight responses; stale ones will never push.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    int committed;
    committed = int'(occupancy) + int'(outstanding) - int'(drop);
    can_issue = 1'b0;
    if (outstanding < OW'(MAX_OUTSTANDING) && committed < int'(DEPTH)) can_issue = 1'b1;
  end

  assign imem_req  = !rst && !redirect_valid && can_issue;
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_gnt;
  assign push      = imem_rvalid && (drop == '0) && !redirect_valid;

  assign head_valid  = (occupancy != '0);
  assign out_valid   = head_valid && !redirect_valid;
  assign pop         = out_valid && out_ready;
  assign out_instr   = head_valid ? head.instr : '0;
  assign out_pc      = head_valid ? head.pc : '0;
  assign out_pcplus4 = out_pc + XLEN'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + OW'(fire) - OW'(imem_rvalid);
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        drop     <= outstanding - OW'(imem_rvalid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (push) resp_pc <= resp_pc + XLEN'(PC_STEP);
        if (imem_rvalid && drop != '0) drop <= drop - 1'b1;
      end
    end
  end

  fq_ring_buffer #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push),
    .push_data ('{pc: resp_pc, instr: imem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (occupancy)
  );

  a_rvalid_tracked: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (outstanding != '0));

endmodule
